// File: rtl/fp_mul_pipe.sv
// Three-stage FP16 (1/5/10) multiplier feeding the PE adder: unpack, multiply, normalize/pack.
// Infinity has exponent 31 with zero fraction (no NaN), denormals supported, truncation only.
module fp_mul_pipe #(
    parameter int BIAS = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        valid_i,
    input  logic [15:0] opA_i,
    input  logic [15:0] opB_i,
    output logic [15:0] MUL_o,
    output logic        valid_o
);

    logic              vld_p0;
    logic              sign_p0, inf_p0, zero_p0;
    logic [4:0]        ea_p0, eb_p0;
    logic [10:0]       ma_p0, mb_p0;

    logic              vld_p1;
    logic              sign_p1, inf_p1, zero_p1;
    logic [21:0]       prod_p1;
    logic signed [6:0] er_p1;

    // Normalize the 22-bit product (value P*2^-20), pack into FP16 with truncation.
    function automatic logic [15:0] pack(input logic sign, input logic inf, input logic zero,
                                         input logic [21:0] p, input logic signed [6:0] er);
        logic [15:0]       r;
        logic [21:0]       pn;
        logic [21:0]       d;
        logic signed [7:0] e;
        logic [4:0]        sh;
        logic [5:0]        dsh;
        sh  = 5'd0;
        pn  = p;
        d   = 22'd0;
        dsh = 6'd0;
        e   = {er[6], er};
        for (int i = 0; i <= 20; i++) begin
            if (p[i]) sh = 5'(20 - i);
        end
        if (inf) begin
            r = {sign, 5'b11111, 10'b0};
        end else if (zero || p == 22'd0) begin
            r = 16'h0000;
        end else begin
            if (p[21]) begin
                pn = p >> 1;
                e  = e + 8'sd1;
            end else begin
                pn = p << sh;
                e  = e - $signed({3'b000, sh});
            end
            if (e >= 8'sd31) begin
                r = {sign, 5'b11111, 10'b0};
            end else if (e >= 8'sd1) begin
                r = {sign, e[4:0], pn[19:10]};
            end else begin
                dsh = 6'(8'sd1 - e);
                d   = (dsh >= 6'd21) ? 22'd0 : (pn >> dsh);
                r   = (d[19:10] == 10'd0) ? 16'h0000 : {sign, 5'b00000, d[19:10]};
            end
        end
        return r;
    endfunction

    // Stage 1: unpack operands and classify specials
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p0  <= 1'b0;
            sign_p0 <= 1'b0;
            inf_p0  <= 1'b0;
            zero_p0 <= 1'b0;
            ea_p0   <= 5'd0;
            eb_p0   <= 5'd0;
            ma_p0   <= 11'd0;
            mb_p0   <= 11'd0;
        end else if (en_i) begin
            vld_p0  <= valid_i;
            sign_p0 <= opA_i[15] ^ opB_i[15];
            inf_p0  <= (opA_i[14:10] == 5'd31) || (opB_i[14:10] == 5'd31);
            zero_p0 <= (opA_i[14:0] == 15'd0) || (opB_i[14:0] == 15'd0);
            ea_p0   <= (opA_i[14:10] == 5'd0) ? 5'd1 : opA_i[14:10];
            eb_p0   <= (opB_i[14:10] == 5'd0) ? 5'd1 : opB_i[14:10];
            ma_p0   <= {|opA_i[14:10], opA_i[9:0]};
            mb_p0   <= {|opB_i[14:10], opB_i[9:0]};
        end
    end

    // Stage 2: mantissa product and unbiased exponent sum
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p1  <= 1'b0;
            sign_p1 <= 1'b0;
            inf_p1  <= 1'b0;
            zero_p1 <= 1'b0;
            prod_p1 <= 22'd0;
            er_p1   <= 7'sd0;
        end else if (en_i) begin
            vld_p1  <= vld_p0;
            sign_p1 <= sign_p0;
            inf_p1  <= inf_p0;
            zero_p1 <= zero_p0;
            prod_p1 <= ma_p0 * mb_p0;
            er_p1   <= $signed(7'({2'b00, ea_p0} + {2'b00, eb_p0}) - 7'(BIAS));
        end
    end

    // Stage 3: normalize, apply special priority, register result
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            MUL_o   <= 16'h0000;
        end else if (en_i) begin
            valid_o <= vld_p1;
            MUL_o   <= pack(sign_p1, inf_p1, zero_p1, prod_p1, er_p1);
        end
    end

endmodule
